// File: rtl/ex_issue_ctrl.sv
// Issue controller on the ID side of the execution block: issues one instruction at a time,
// owns the intermediate-value registers and holds the EX result until writeback accepts it.
module ex_issue_ctrl #(
  parameter int unsigned MaxCycles = 40,
  parameter int unsigned CntWidth  = 6
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                instr_valid_i,
  input  logic [1:0]          instr_kind_i,
  output logic                instr_ready_o,
  input  logic                flush_i,
  output logic                alu_instr_first_cycle_o,
  output logic                mult_en_o,
  output logic                div_en_o,
  output logic                multdiv_ready_id_o,
  input  logic                ex_valid_i,
  input  logic [31:0]         result_ex_i,
  input  logic [1:0]          imd_val_we_i,
  input  logic [33:0]         imd_val_d0_i,
  input  logic [33:0]         imd_val_d1_i,
  output logic [33:0]         imd_val_q0_o,
  output logic [33:0]         imd_val_q1_o,
  output logic                wb_valid_o,
  output logic [31:0]         wb_data_o,
  input  logic                wb_ready_i,
  output logic                busy_o,
  output logic [CntWidth-1:0] exec_cycles_o,
  output logic                err_timeout_o
);

  typedef enum logic [1:0] {StIdle, StExec, StWbHold} state_e;

  localparam logic [1:0]          KindMult = 2'd1;
  localparam logic [1:0]          KindDiv  = 2'd2;
  localparam logic [CntWidth-1:0] CntSat   = {CntWidth{1'b1}};
  localparam logic [CntWidth-1:0] CntLimit = CntWidth'(MaxCycles);
  localparam logic [CntWidth-1:0] CntOne   = CntWidth'(1);

  state_e              r_state;
  logic [1:0]          r_kind;
  logic [CntWidth-1:0] r_cnt;
  logic                r_first;
  logic                r_err;
  logic [31:0]         r_wb_data;
  logic [33:0]         r_imd0;
  logic [33:0]         r_imd1;

  logic w_idle;
  logic w_exec;
  logic w_hold;
  logic w_ready;
  logic w_accept;
  logic w_imd_ok;

  assign w_idle   = (r_state == StIdle);
  assign w_exec   = (r_state == StExec);
  assign w_hold   = (r_state == StWbHold);
  // A held result frees the slot in the same cycle it is consumed, allowing back-to-back issue.
  assign w_ready  = !flush_i && (w_idle || (w_hold && wb_ready_i));
  assign w_accept = instr_valid_i && w_ready;
  assign w_imd_ok = w_exec && !flush_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state   <= StIdle;
      r_kind    <= 2'd0;
      r_cnt     <= '0;
      r_first   <= 1'b0;
      r_err     <= 1'b0;
      r_wb_data <= 32'd0;
      r_imd0    <= 34'd0;
      r_imd1    <= 34'd0;
    end else begin
      r_err <= 1'b0;
      if (w_imd_ok && imd_val_we_i[0]) begin
        r_imd0 <= imd_val_d0_i;
      end
      if (w_imd_ok && imd_val_we_i[1]) begin
        r_imd1 <= imd_val_d1_i;
      end
      unique case (r_state)
        StIdle: begin
          if (w_accept) begin
            r_state <= StExec;
            r_kind  <= instr_kind_i;
            r_cnt   <= CntOne;
            r_first <= 1'b1;
          end
        end
        StExec: begin
          r_first <= 1'b0;
          if (flush_i) begin
            r_state <= StIdle;
          end else if (ex_valid_i) begin
            r_wb_data <= result_ex_i;
            r_state   <= StWbHold;
          end else if (r_cnt == CntLimit) begin
            r_state <= StIdle;
            r_err   <= 1'b1;
          end else if (r_cnt != CntSat) begin
            r_cnt <= r_cnt + CntOne;
          end
        end
        StWbHold: begin
          if (flush_i) begin
            r_state <= StIdle;
          end else if (wb_ready_i) begin
            if (w_accept) begin
              r_state <= StExec;
              r_kind  <= instr_kind_i;
              r_cnt   <= CntOne;
              r_first <= 1'b1;
            end else begin
              r_state <= StIdle;
            end
          end
        end
        default: begin
          r_state <= StIdle;
        end
      endcase
    end
  end

  assign instr_ready_o           = w_ready;
  assign alu_instr_first_cycle_o = w_exec && r_first;
  assign mult_en_o               = w_exec && (r_kind == KindMult);
  assign div_en_o                = w_exec && (r_kind == KindDiv);
  assign multdiv_ready_id_o      = w_exec;
  assign imd_val_q0_o            = r_imd0;
  assign imd_val_q1_o            = r_imd1;
  assign wb_valid_o              = w_hold;
  assign wb_data_o               = r_wb_data;
  assign busy_o                  = !w_idle;
  assign exec_cycles_o           = r_cnt;
  assign err_timeout_o           = r_err;

endmodule

// File: tb/tb_ex_issue_ctrl.sv
// Directed self-checking bench for ex_issue_ctrl with hand-computed expectations.
module tb_ex_issue_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        instr_valid_i;
  logic [1:0]  instr_kind_i;
  logic        instr_ready_o;
  logic        flush_i;
  logic        alu_instr_first_cycle_o;
  logic        mult_en_o;
  logic        div_en_o;
  logic        multdiv_ready_id_o;
  logic        ex_valid_i;
  logic [31:0] result_ex_i;
  logic [1:0]  imd_val_we_i;
  logic [33:0] imd_val_d0_i;
  logic [33:0] imd_val_d1_i;
  logic [33:0] imd_val_q0_o;
  logic [33:0] imd_val_q1_o;
  logic        wb_valid_o;
  logic [31:0] wb_data_o;
  logic        wb_ready_i;
  logic        busy_o;
  logic [5:0]  exec_cycles_o;
  logic        err_timeout_o;

  int checks   = 0;
  int failures = 0;

  always #5 clk_i = ~clk_i;

  ex_issue_ctrl #(
    .MaxCycles(40),
    .CntWidth (6)
  ) u_dut (
    .clk_i                  (clk_i),
    .rst_i                  (rst_i),
    .instr_valid_i          (instr_valid_i),
    .instr_kind_i           (instr_kind_i),
    .instr_ready_o          (instr_ready_o),
    .flush_i                (flush_i),
    .alu_instr_first_cycle_o(alu_instr_first_cycle_o),
    .mult_en_o              (mult_en_o),
    .div_en_o               (div_en_o),
    .multdiv_ready_id_o     (multdiv_ready_id_o),
    .ex_valid_i             (ex_valid_i),
    .result_ex_i            (result_ex_i),
    .imd_val_we_i           (imd_val_we_i),
    .imd_val_d0_i           (imd_val_d0_i),
    .imd_val_d1_i           (imd_val_d1_i),
    .imd_val_q0_o           (imd_val_q0_o),
    .imd_val_q1_o           (imd_val_q1_o),
    .wb_valid_o             (wb_valid_o),
    .wb_data_o              (wb_data_o),
    .wb_ready_i             (wb_ready_i),
    .busy_o                 (busy_o),
    .exec_cycles_o          (exec_cycles_o),
    .err_timeout_o          (err_timeout_o)
  );

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    tick();
    tick();
    #1;
    checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL rst_busy got=%0b exp=0", busy_o); end
    checks++; if (wb_valid_o !== 1'b0) begin failures++; $display("FAIL rst_wb_valid got=%0b exp=0", wb_valid_o); end
    checks++; if (wb_data_o !== 32'd0) begin failures++; $display("FAIL rst_wb_data got=%h exp=0", wb_data_o); end
    checks++; if (exec_cycles_o !== 6'd0) begin failures++; $display("FAIL rst_cnt got=%0d exp=0", exec_cycles_o); end
    checks++; if (err_timeout_o !== 1'b0) begin failures++; $display("FAIL rst_err got=%0b exp=0", err_timeout_o); end
    checks++; if (imd_val_q0_o !== 34'd0 || imd_val_q1_o !== 34'd0) begin failures++; $display("FAIL rst_imd got=%h/%h exp=0/0", imd_val_q0_o, imd_val_q1_o); end
    checks++; if ({alu_instr_first_cycle_o, mult_en_o, div_en_o, multdiv_ready_id_o} !== 4'b0000) begin
      failures++; $display("FAIL rst_exec_outs got=%b exp=0000", {alu_instr_first_cycle_o, mult_en_o, div_en_o, multdiv_ready_id_o});
    end
    checks++; if (instr_ready_o !== 1'b1) begin failures++; $display("FAIL rst_ready got=%0b exp=1", instr_ready_o); end
    rst_i = 1'b0;
    tick();
  endtask

  task automatic test_alu();
    instr_valid_i = 1'b1;
    instr_kind_i  = 2'd0;
    #1;
    checks++; if (instr_ready_o !== 1'b1) begin failures++; $display("FAIL alu_ready got=%0b exp=1", instr_ready_o); end
    tick();
    instr_valid_i = 1'b0;
    ex_valid_i    = 1'b1;
    result_ex_i   = 32'hDEADBEEF;
    wb_ready_i    = 1'b1;
    #1;
    checks++; if (alu_instr_first_cycle_o !== 1'b1) begin failures++; $display("FAIL alu_first got=%0b exp=1", alu_instr_first_cycle_o); end
    checks++; if (multdiv_ready_id_o !== 1'b1 || mult_en_o !== 1'b0 || div_en_o !== 1'b0) begin
      failures++; $display("FAIL alu_en got=%b exp=100", {multdiv_ready_id_o, mult_en_o, div_en_o});
    end
    checks++; if (busy_o !== 1'b1) begin failures++; $display("FAIL alu_busy got=%0b exp=1", busy_o); end
    tick();
    ex_valid_i = 1'b0;
    #1;
    checks++; if (wb_valid_o !== 1'b1) begin failures++; $display("FAIL alu_wb_valid got=%0b exp=1", wb_valid_o); end
    checks++; if (wb_data_o !== 32'hDEADBEEF) begin failures++; $display("FAIL alu_wb_data got=%h exp=deadbeef", wb_data_o); end
    checks++; if (exec_cycles_o !== 6'd1) begin failures++; $display("FAIL alu_cnt got=%0d exp=1", exec_cycles_o); end
    tick();
    wb_ready_i = 1'b0;
    #1;
    checks++; if (busy_o !== 1'b0 || wb_valid_o !== 1'b0) begin failures++; $display("FAIL alu_idle got=%b exp=00", {busy_o, wb_valid_o}); end
  endtask

  task automatic test_div();
    instr_valid_i = 1'b1;
    instr_kind_i  = 2'd2;
    tick();
    instr_valid_i = 1'b0;
    for (int i = 0; i < 34; i++) begin
      imd_val_we_i = 2'b11;
      imd_val_d0_i = 34'(i);
      imd_val_d1_i = 34'h2_0000_0000 | 34'(i);
      ex_valid_i   = (i == 33);
      result_ex_i  = 32'h0000_1111;
      #1;
      checks++; if (div_en_o !== 1'b1 || mult_en_o !== 1'b0) begin
        failures++; $display("FAIL div_en cyc=%0d got=%b exp=10", i, {div_en_o, mult_en_o});
      end
      tick();
    end
    ex_valid_i   = 1'b0;
    imd_val_d0_i = 34'h55;
    imd_val_d1_i = 34'h66;
    #1;
    checks++; if (imd_val_q0_o !== 34'd33) begin failures++; $display("FAIL div_q0 got=%h exp=21", imd_val_q0_o); end
    checks++; if (imd_val_q1_o !== 34'h2_0000_0021) begin failures++; $display("FAIL div_q1 got=%h exp=200000021", imd_val_q1_o); end
    checks++; if (exec_cycles_o !== 6'd34) begin failures++; $display("FAIL div_cnt got=%0d exp=34", exec_cycles_o); end
    checks++; if (wb_valid_o !== 1'b1 || div_en_o !== 1'b0) begin failures++; $display("FAIL div_hold got=%b exp=10", {wb_valid_o, div_en_o}); end
    tick();
    imd_val_we_i = 2'b00;
    wb_ready_i   = 1'b1;
    #1;
    checks++; if (imd_val_q0_o !== 34'd33) begin failures++; $display("FAIL div_imd_hold_write got=%h exp=21", imd_val_q0_o); end
    tick();
    wb_ready_i = 1'b0;
    #1;
    checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL div_idle got=%0b exp=0", busy_o); end
  endtask

  task automatic test_timeout();
    instr_valid_i = 1'b1;
    instr_kind_i  = 2'd1;
    tick();
    instr_valid_i = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      #1;
      checks++; if (busy_o !== 1'b1 || mult_en_o !== 1'b1 || wb_valid_o !== 1'b0 || err_timeout_o !== 1'b0) begin
        failures++; $display("FAIL to_exec cyc=%0d got=%b exp=1100", c, {busy_o, mult_en_o, wb_valid_o, err_timeout_o});
      end
      checks++; if (exec_cycles_o !== 6'(c)) begin failures++; $display("FAIL to_cnt got=%0d exp=%0d", exec_cycles_o, c); end
      tick();
    end
    #1;
    checks++; if (busy_o !== 1'b0 || err_timeout_o !== 1'b1) begin failures++; $display("FAIL to_abort got=%b exp=01", {busy_o, err_timeout_o}); end
    checks++; if (exec_cycles_o !== 6'd40) begin failures++; $display("FAIL to_cnt_hold got=%0d exp=40", exec_cycles_o); end
    tick();
    checks++; if (err_timeout_o !== 1'b0 || wb_valid_o !== 1'b0) begin failures++; $display("FAIL to_pulse got=%b exp=00", {err_timeout_o, wb_valid_o}); end
  endtask

  task automatic test_back_to_back();
    instr_valid_i = 1'b1;
    instr_kind_i  = 2'd0;
    tick();
    ex_valid_i  = 1'b1;
    result_ex_i = 32'h1234_5678;
    wb_ready_i  = 1'b0;
    instr_kind_i = 2'd1;
    tick();
    ex_valid_i  = 1'b0;
    result_ex_i = 32'hFFFF_0000;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++; if (instr_ready_o !== 1'b0 || wb_valid_o !== 1'b1 || wb_data_o !== 32'h1234_5678) begin
        failures++; $display("FAIL b2b_stall cyc=%0d got=%b/%h exp=01/12345678", i, {instr_ready_o, wb_valid_o}, wb_data_o);
      end
      tick();
    end
    wb_ready_i = 1'b1;
    #1;
    checks++; if (instr_ready_o !== 1'b1) begin failures++; $display("FAIL b2b_ready got=%0b exp=1", instr_ready_o); end
    tick();
    instr_valid_i = 1'b0;
    wb_ready_i    = 1'b0;
    #1;
    checks++; if (alu_instr_first_cycle_o !== 1'b1 || mult_en_o !== 1'b1 || wb_valid_o !== 1'b0) begin
      failures++; $display("FAIL b2b_issue got=%b exp=110", {alu_instr_first_cycle_o, mult_en_o, wb_valid_o});
    end
    checks++; if (exec_cycles_o !== 6'd1) begin failures++; $display("FAIL b2b_cnt got=%0d exp=1", exec_cycles_o); end
    ex_valid_i  = 1'b1;
    result_ex_i = 32'hCAFE_F00D;
    tick();
    ex_valid_i = 1'b0;
    #1;
    checks++; if (wb_valid_o !== 1'b1 || wb_data_o !== 32'hCAFE_F00D) begin
      failures++; $display("FAIL b2b_wb2 got=%b/%h exp=1/cafef00d", wb_valid_o, wb_data_o);
    end
    // Flush in WB_HOLD beats wb_ready_i and blocks a pending issue.
    flush_i       = 1'b1;
    wb_ready_i    = 1'b1;
    instr_valid_i = 1'b1;
    #1;
    checks++; if (instr_ready_o !== 1'b0) begin failures++; $display("FAIL hold_flush_ready got=%0b exp=0", instr_ready_o); end
    tick();
    flush_i       = 1'b0;
    wb_ready_i    = 1'b0;
    instr_valid_i = 1'b0;
    #1;
    checks++; if (busy_o !== 1'b0 || wb_valid_o !== 1'b0) begin failures++; $display("FAIL hold_flush got=%b exp=00", {busy_o, wb_valid_o}); end
  endtask

  task automatic test_flush_exec();
    instr_valid_i = 1'b1;
    instr_kind_i  = 2'd0;
    tick();
    instr_valid_i = 1'b0;
    flush_i       = 1'b1;
    ex_valid_i    = 1'b1;
    result_ex_i   = 32'h0000_0BAD;
    imd_val_we_i  = 2'b01;
    imd_val_d0_i  = 34'h3_FFFF_FFFF;
    tick();
    flush_i      = 1'b0;
    ex_valid_i   = 1'b0;
    imd_val_we_i = 2'b00;
    #1;
    checks++; if (busy_o !== 1'b0 || wb_valid_o !== 1'b0) begin failures++; $display("FAIL ex_flush got=%b exp=00", {busy_o, wb_valid_o}); end
    checks++; if (wb_data_o !== 32'hCAFE_F00D) begin failures++; $display("FAIL ex_flush_data got=%h exp=cafef00d", wb_data_o); end
    checks++; if (imd_val_q0_o !== 34'd33) begin failures++; $display("FAIL ex_flush_imd got=%h exp=21", imd_val_q0_o); end
    checks++; if (exec_cycles_o !== 6'd1) begin failures++; $display("FAIL ex_flush_cnt got=%0d exp=1", exec_cycles_o); end
    tick();
  endtask

  task automatic test_reset_mid();
    instr_valid_i = 1'b1;
    instr_kind_i  = 2'd2;
    tick();
    instr_valid_i = 1'b0;
    imd_val_we_i  = 2'b11;
    imd_val_d0_i  = 34'h1234;
    imd_val_d1_i  = 34'h5678;
    tick();
    imd_val_we_i = 2'b00;
    #1;
    checks++; if (imd_val_q0_o !== 34'h1234 || imd_val_q1_o !== 34'h5678 || div_en_o !== 1'b1) begin
      failures++; $display("FAIL rm_pre got=%h/%h/%0b exp=1234/5678/1", imd_val_q0_o, imd_val_q1_o, div_en_o);
    end
    rst_i = 1'b1;
    tick();
    checks++; if (busy_o !== 1'b0 || wb_valid_o !== 1'b0 || err_timeout_o !== 1'b0 || div_en_o !== 1'b0) begin
      failures++; $display("FAIL rm_state got=%b exp=0000", {busy_o, wb_valid_o, err_timeout_o, div_en_o});
    end
    checks++; if (imd_val_q0_o !== 34'd0 || imd_val_q1_o !== 34'd0) begin
      failures++; $display("FAIL rm_imd got=%h/%h exp=0/0", imd_val_q0_o, imd_val_q1_o);
    end
    checks++; if (exec_cycles_o !== 6'd0 || wb_data_o !== 32'd0) begin
      failures++; $display("FAIL rm_regs got=%0d/%h exp=0/0", exec_cycles_o, wb_data_o);
    end
    rst_i = 1'b0;
    tick();
  endtask

  initial begin
    rst_i         = 1'b1;
    instr_valid_i = 1'b0;
    instr_kind_i  = 2'd0;
    flush_i       = 1'b0;
    ex_valid_i    = 1'b0;
    result_ex_i   = 32'd0;
    imd_val_we_i  = 2'b00;
    imd_val_d0_i  = 34'd0;
    imd_val_d1_i  = 34'd0;
    wb_ready_i    = 1'b0;
    test_reset();
    test_alu();
    test_div();
    test_timeout();
    test_back_to_back();
    test_flush_exec();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ex_issue_ctrl.md
Name: ex_issue_ctrl

Overview:
ID-side controller that drives the execution block and collects its results. It issues one decoded instruction at a time, generating first-cycle, multiplier/divider enable and ready strobes. It owns the two 34-bit intermediate-value registers written by the EX block and returns their contents to it. It captures the EX result into a writeback holding register with a valid/ready handshake, and provides flush and a watchdog timeout.

Parameters:
MaxCycles, 40, EXEC cycles allowed before timeout abort (range 2..2^CntWidth-1).
CntWidth, 6, width of the EXEC cycle counter.

Ports:
clk_i  in  1  clock
rst_i  in  1  reset; synchronous, active-high
instr_valid_i  in  1  decoded instruction offered
instr_kind_i  in  2  0=ALU, 1=MULT, 2=DIV, 3=CRYPTO (SHA2/AES)
instr_ready_o  out  1  instruction accepted this cycle when high together with instr_valid_i
flush_i  in  1  abort in-flight instruction
alu_instr_first_cycle_o  out  1  first EXEC cycle of the current instruction
mult_en_o  out  1  dynamic multiplier enable
div_en_o  out  1  dynamic divider enable
multdiv_ready_id_o  out  1  ID ready to take the multdiv result
ex_valid_i  in  1  EX result valid
result_ex_i  in  32  EX result
imd_val_we_i  in  2  per-entry intermediate-value write enable
imd_val_d0_i, imd_val_d1_i  in  34 each  intermediate-value write data
imd_val_q0_o, imd_val_q1_o  out  34 each  intermediate-value register contents
wb_valid_o  out  1  writeback data valid
wb_data_o  out  32  writeback data
wb_ready_i  in  1  writeback consumer ready
busy_o  out  1  state != IDLE
exec_cycles_o  out  CntWidth  EXEC cycles spent by the current or last instruction
err_timeout_o  out  1  one-cycle pulse on watchdog abort

Behaviour:
- Reset values: state=IDLE; imd_val_q*=0; wb_data_o=0; exec_cycles_o=0; kind reg=0; err_timeout_o=0. All other outputs follow from IDLE.
- States: IDLE, EXEC, WB_HOLD.
- instr_ready_o = !flush_i & (IDLE | (WB_HOLD & wb_ready_i)).
- Accept = instr_valid_i & instr_ready_o. On accept: register instr_kind_i, set counter to 1, go to EXEC.
- EXEC outputs:
  - alu_instr_first_cycle_o=1 in the first EXEC cycle only.
  - mult_en_o = (kind==MULT); div_en_o = (kind==DIV).
  - multdiv_ready_id_o=1.
  - All four are 0 outside EXEC.
- EXEC transitions, by priority:
  1. flush_i: go to IDLE; no wb.
  2. ex_valid_i: wb_data_o<=result_ex_i; go to WB_HOLD.
  3. counter==MaxCycles: go to IDLE; err_timeout_o=1 next cycle.
  4. Otherwise: counter++, saturating at 2^CntWidth-1.
- exec_cycles_o shows the counter and holds its value after leaving EXEC.
- WB_HOLD: wb_valid_o=1, and wb_data_o is stable until the handshake completes.
  - wb_valid & wb_ready_i: go to IDLE, or straight to EXEC if accept occurs in the same cycle (back-to-back).
  - flush_i: go to IDLE; the pending wb is dropped, and flush wins over wb_ready_i.
- Intermediate-value registers: entry k <= imd_val_dk_i when imd_val_we_i[k] & state==EXEC & !flush_i. Writes in other states are ignored. Contents persist across instructions and are cleared only by reset.
- Latency: accept at cycle T; EXEC starts at T+1. For a single-cycle op (ex_valid_i at T+1), wb_valid_o=1 at T+2. An op with ex_valid_i at T+n gives wb_valid_o at T+n+1.
- Reset asserted mid-operation: the next cycle is IDLE with reset values; no wb and no error pulse.

Test Plan:
- ALU op kind=0, ex_valid_i=1 in first EXEC cycle, result 0xDEADBEEF, wb_ready_i=1 -> first_cycle=1 at T+1; wb_valid_o=1 with wb_data_o=0xDEADBEEF at T+2; exec_cycles_o=1; IDLE at T+3.
- DIV kind=2, ex_valid_i after 34 cycles, imd_val_we_i=2'b11 each cycle with d0=cycle index -> div_en_o high for 34 cycles; imd_val_q0_o=33 at end; exec_cycles_o=34; mult_en_o never high.
- MULT with ex_valid_i never asserted, MaxCycles=40 -> exactly 40 EXEC cycles; err_timeout_o single pulse; wb_valid_o never high; IDLE afterwards.
- wb_ready_i=0 for 5 cycles while a new instr_valid_i is pending -> wb_data_o stable, instr_ready_o=0; on wb_ready_i=1 the new instruction is accepted that cycle and first_cycle=1 next cycle.
- flush_i together with ex_valid_i in EXEC, and flush_i in WB_HOLD with wb_ready_i=1 -> IDLE next cycle, no wb handshake, imd write in the flush cycle suppressed.
- rst_i asserted during EXEC of a DIV with imd regs nonzero -> next cycle busy_o=0, imd_val_q*=0, wb_valid_o=0, err_timeout_o=0.
